// File: rtl/uart_rx_deser.sv
// Oversampling UART receiver. It turns the asynchronous rx line (8N1, with an
// optional parity bit) into bytes for the downstream 8-to-32 packing FIFO.
// Handshake: data_valid is a one-cycle write strobe that travels with data_out.
// There is no ready signal. While fifo_full is high, a good byte is dropped and
// overrun_err pulses instead of data_valid.
module uart_rx_deser #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 fifo_full,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SMP_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] HALF_LAST = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SMP_W-1:0] FULL_LAST = SMP_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic             PAR_ODD   = (PARITY_ODD != 0);

    if (DIV < 1) begin : g_bad_div
        $error("uart_rx_deser: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
    end
    if ((OVERSAMPLE < 8) || ((OVERSAMPLE % 2) != 0)) begin : g_bad_os
        $error("uart_rx_deser: OVERSAMPLE must be even and >= 8");
    end

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Current receiver state. It is a named signal so that checkers can bind to it.
    state_t               state;
    logic                 sync1;
    logic                 rx_s;
    logic                 rx_prev;
    logic [DIV_W-1:0]     div_cnt;
    logic [SMP_W-1:0]     smp_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bad;
    logic                 tick;
    logic                 start_det;

    assign tick      = (div_cnt == DIV_LAST);
    assign start_det = (state == IDLE) && rx_prev && !rx_s;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= rx;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    // Oversample tick divider, realigned to the start-bit falling edge.
    always_ff @(posedge clk) begin
        if (rst || start_det || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Frame FSM: samples at bit midpoints, shifts data, and emits exactly one outcome pulse per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            smp_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bad     <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_det) begin
                        state   <= START;
                        busy    <= 1'b1;
                        smp_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (smp_cnt == HALF_LAST) begin
                            smp_cnt <= '0;
                            bit_cnt <= '0;
                            par_bad <= 1'b0;
                            if (!rx_s) begin
                                state <= DATA;
                            end else begin
                                // A glitch shorter than half a bit is not a start bit.
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (smp_cnt == FULL_LAST) begin
                            smp_cnt <= '0;
                            shift   <= {rx_s, shift[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == BITS_LAST) begin
                                state <= (PARITY_EN != 0) ? PARITY : STOP;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        if (smp_cnt == FULL_LAST) begin
                            smp_cnt <= '0;
                            par_bad <= (rx_s != ((^shift) ^ PAR_ODD));
                            state   <= STOP;
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (smp_cnt == FULL_LAST) begin
                            // Leave at mid-stop so the next start edge is not missed.
                            smp_cnt <= '0;
                            state   <= IDLE;
                            busy    <= 1'b0;
                            if (!rx_s) begin
                                frame_err <= 1'b1;
                            end else if (par_bad) begin
                                parity_err <= 1'b1;
                            end else if (fifo_full) begin
                                overrun_err <= 1'b1;
                            end else begin
                                data_out   <= shift;
                                data_valid <= 1'b1;
                            end
                        end else begin
                            smp_cnt <= smp_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser. One instance runs without parity and a second runs
// with even parity. Randomised frames are checked against a frame-level outcome model.
module tb_uart_rx_deser;

    localparam int CLK_FREQ    = 1_600_000;
    localparam int BAUD        = 100_000;
    localparam int OVERSAMPLE  = 16;
    localparam int BIT_CLK     = CLK_FREQ / BAUD;
    localparam int OUT_VALID   = 0;
    localparam int OUT_FRAME   = 1;
    localparam int OUT_PARITY  = 2;
    localparam int OUT_OVERRUN = 3;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       rx0, rx1, full0, full1;
    logic [7:0] dout0, dout1;
    logic       dv0, fe0, pe0, ov0, busy0;
    logic       dv1, fe1, pe1, ov1, busy1;

    uart_rx_deser #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE),
                    .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .fifo_full(full0),
        .data_out(dout0), .data_valid(dv0), .frame_err(fe0),
        .parity_err(pe0), .overrun_err(ov0), .busy(busy0)
    );

    uart_rx_deser #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE),
                    .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .fifo_full(full1),
        .data_out(dout1), .data_valid(dv1), .frame_err(fe1),
        .parity_err(pe1), .overrun_err(ov1), .busy(busy1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // event monitors (sampled on the falling edge)
    int         dv_cnt0 = 0, fe_cnt0 = 0, pe_cnt0 = 0, ov_cnt0 = 0, dv_cyc0 = 0;
    int         dv_cnt1 = 0, fe_cnt1 = 0, pe_cnt1 = 0, ov_cnt1 = 0;
    logic [7:0] got0 [0:1023];
    logic [7:0] got1 [0:1023];

    always @(negedge clk) begin
        if (dv0) begin
            if (dv_cnt0 < 1024) got0[dv_cnt0] = dout0;
            dv_cnt0++;
            dv_cyc0 = cyc;
        end
        if (fe0) fe_cnt0++;
        if (pe0) pe_cnt0++;
        if (ov0) ov_cnt0++;
        if (dv1) begin
            if (dv_cnt1 < 1024) got1[dv_cnt1] = dout1;
            dv_cnt1++;
        end
        if (fe1) fe_cnt1++;
        if (pe1) pe_cnt1++;
        if (ov1) ov_cnt1++;
    end

    int         checks = 0;
    int         errors = 0;
    int         start_cyc0 = 0;
    logic [7:0] last_good [2];

    // reference model: outcome of one whole frame
    function automatic int model_outcome(input logic [7:0] d, input bit has_par, input bit par,
                                         input bit stop, input bit full);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (!stop) return OUT_FRAME;
        if (has_par && (par != bit'(ones % 2))) return OUT_PARITY;
        if (full) return OUT_OVERRUN;
        return OUT_VALID;
    endfunction

    function automatic logic [7:0] got_at(input int which, input int idx);
        if (idx < 0 || idx >= 1024) return 8'hxx;
        return (which == 0) ? got0[idx] : got1[idx];
    endfunction

    function automatic logic [7:0] dout_of(input int which);
        return (which == 0) ? dout0 : dout1;
    endfunction

    // driver tasks
    task automatic snap(input int which, output int dv, output int fe, output int pe, output int ov);
        if (which == 0) begin
            dv = dv_cnt0; fe = fe_cnt0; pe = pe_cnt0; ov = ov_cnt0;
        end else begin
            dv = dv_cnt1; fe = fe_cnt1; pe = pe_cnt1; ov = ov_cnt1;
        end
    endtask

    task automatic drive_bit(input int which, input logic b);
        if (which == 0) rx0 = b;
        else rx1 = b;
        repeat (BIT_CLK) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input logic par, input logic stop);
        if (which == 0) start_cyc0 = cyc;
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (which == 1) drive_bit(which, par);
        drive_bit(which, stop);
    endtask

    task automatic test_reset();
        rst = 1'b1; rx0 = 1'b1; rx1 = 1'b1; full0 = 1'b0; full1 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({dout0, dv0, fe0, pe0, ov0, busy0} !== 13'd0) begin
            errors++;
            $display("FAIL reset_dut0: got %h expected 0", {dout0, dv0, fe0, pe0, ov0, busy0});
        end
        checks++;
        if ({dout1, dv1, fe1, pe1, ov1, busy1} !== 13'd0) begin
            errors++;
            $display("FAIL reset_dut1: got %h expected 0", {dout1, dv1, fe1, pe1, ov1, busy1});
        end
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
    endtask

    task automatic test_basic();
        int bdv, bfe, bpe, bov, adv, afe, ape, aov, lat;
        snap(0, bdv, bfe, bpe, bov);
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        snap(0, adv, afe, ape, aov);
        checks++;
        if ({adv - bdv, afe - bfe, ape - bpe, aov - bov} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL basic_events: dv %0d fe %0d pe %0d ov %0d expected 1 0 0 0",
                     adv - bdv, afe - bfe, ape - bpe, aov - bov);
        end
        checks++;
        if (got_at(0, bdv) !== 8'hA5) begin
            errors++;
            $display("FAIL basic_data: got %h expected a5", got_at(0, bdv));
        end
        lat = dv_cyc0 - start_cyc0;
        checks++;
        if (lat < 152 || lat > 155) begin
            errors++;
            $display("FAIL basic_latency: got %0d expected 152..155", lat);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: got %b expected 0", busy0);
        end
        last_good[0] = 8'hA5;
    endtask

    task automatic test_false_start();
        int bdv, bfe, bpe, bov, adv, afe, ape, aov;
        snap(0, bdv, bfe, bpe, bov);
        rx0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx0 = 1'b1;
        checks++;
        if (busy0 !== 1'b1) begin
            errors++;
            $display("FAIL false_start_busy_high: got %b expected 1", busy0);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL false_start_busy_drop: got %b expected 0", busy0);
        end
        drive_bit(0, 1'b1);
        snap(0, adv, afe, ape, aov);
        checks++;
        if ({adv - bdv, afe - bfe, ape - bpe, aov - bov} !== {32'd0, 32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL false_start_events: dv %0d fe %0d pe %0d ov %0d expected 0 0 0 0",
                     adv - bdv, afe - bfe, ape - bpe, aov - bov);
        end
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        checks++;
        if (dv_cnt0 - bdv !== 1 || got_at(0, bdv) !== 8'h5A) begin
            errors++;
            $display("FAIL false_start_next: dv %0d data %h expected 1 5a", dv_cnt0 - bdv, got_at(0, bdv));
        end
        last_good[0] = 8'h5A;
    endtask

    task automatic test_frame_err();
        int bdv, bfe, bpe, bov, adv, afe, ape, aov;
        snap(0, bdv, bfe, bpe, bov);
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        repeat (40 * BIT_CLK) @(posedge clk);
        #1;
        snap(0, adv, afe, ape, aov);
        checks++;
        if ({adv - bdv, afe - bfe, ape - bpe, aov - bov} !== {32'd0, 32'd1, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL frame_err_events: dv %0d fe %0d pe %0d ov %0d expected 0 1 0 0",
                     adv - bdv, afe - bfe, ape - bpe, aov - bov);
        end
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL frame_err_break_busy: got %b expected 0", busy0);
        end
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        send_frame(0, 8'h81, 1'b0, 1'b1);
        checks++;
        if (dv_cnt0 - adv !== 1 || got_at(0, adv) !== 8'h81) begin
            errors++;
            $display("FAIL frame_err_recover: dv %0d data %h expected 1 81", dv_cnt0 - adv, got_at(0, adv));
        end
        last_good[0] = 8'h81;
    endtask

    task automatic test_overrun();
        int bdv, bfe, bpe, bov, adv, afe, ape, aov;
        snap(0, bdv, bfe, bpe, bov);
        full0 = 1'b1;
        send_frame(0, 8'h77, 1'b0, 1'b1);
        full0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        snap(0, adv, afe, ape, aov);
        checks++;
        if ({adv - bdv, afe - bfe, ape - bpe, aov - bov} !== {32'd0, 32'd0, 32'd0, 32'd1}) begin
            errors++;
            $display("FAIL overrun_events: dv %0d fe %0d pe %0d ov %0d expected 0 0 0 1",
                     adv - bdv, afe - bfe, ape - bpe, aov - bov);
        end
        checks++;
        if (dout0 !== last_good[0]) begin
            errors++;
            $display("FAIL overrun_hold: got %h expected %h", dout0, last_good[0]);
        end
    endtask

    task automatic test_parity();
        int bdv, bfe, bpe, bov, adv, afe, ape, aov;
        snap(1, bdv, bfe, bpe, bov);
        send_frame(1, 8'h03, 1'b1, 1'b1);
        snap(1, adv, afe, ape, aov);
        checks++;
        if ({adv - bdv, afe - bfe, ape - bpe, aov - bov} !== {32'd0, 32'd0, 32'd1, 32'd0}) begin
            errors++;
            $display("FAIL parity_bad_events: dv %0d fe %0d pe %0d ov %0d expected 0 0 1 0",
                     adv - bdv, afe - bfe, ape - bpe, aov - bov);
        end
        send_frame(1, 8'h03, 1'b0, 1'b1);
        snap(1, bdv, bfe, bpe, bov);
        checks++;
        if ({bdv - adv, bfe - afe, bpe - ape, bov - aov} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL parity_good_events: dv %0d fe %0d pe %0d ov %0d expected 1 0 0 0",
                     bdv - adv, bfe - afe, bpe - ape, bov - aov);
        end
        checks++;
        if (got_at(1, adv) !== 8'h03) begin
            errors++;
            $display("FAIL parity_good_data: got %h expected 03", got_at(1, adv));
        end
        last_good[1] = 8'h03;
    endtask

    task automatic test_reset_mid();
        int bdv, bfe, bpe, bov, adv, afe, ape, aov;
        logic [7:0] d;
        d = 8'h5F;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, d[i]);
        rx0 = d[4];
        repeat (BIT_CLK / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({dout0, dv0, fe0, pe0, ov0, busy0} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_dut0: got %h expected 0", {dout0, dv0, fe0, pe0, ov0, busy0});
        end
        checks++;
        if (dout1 !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid_dut1: got %h expected 00", dout1);
        end
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;
        snap(0, bdv, bfe, bpe, bov);
        rx0 = 1'b1;
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        send_frame(0, 8'hC3, 1'b0, 1'b1);
        snap(0, adv, afe, ape, aov);
        checks++;
        if ({adv - bdv, afe - bfe, ape - bpe, aov - bov} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_mid_events: dv %0d fe %0d pe %0d ov %0d expected 1 0 0 0",
                     adv - bdv, afe - bfe, ape - bpe, aov - bov);
        end
        checks++;
        if (got_at(0, bdv) !== 8'hC3) begin
            errors++;
            $display("FAIL reset_mid_data: got %h expected c3", got_at(0, bdv));
        end
        last_good[0] = 8'hC3;
    endtask

    task automatic test_back_to_back();
        int bdv;
        logic [7:0]  exp_q[$];
        logic [31:0] word;
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        bdv = dv_cnt0;
        foreach (exp_q[i]) send_frame(0, exp_q[i], 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (dv_cnt0 - bdv !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 4", dv_cnt0 - bdv);
        end
        word = 32'h0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_at(0, bdv + i) !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %h expected %h", i, got_at(0, bdv + i), exp_q[i]);
            end
            word = {word[23:0], got_at(0, bdv + i)};
        end
        checks++;
        if (word !== 32'h11223344) begin
            errors++;
            $display("FAIL b2b_word: got %h expected 11223344", word);
        end
        last_good[0] = 8'h44;
    endtask

    task automatic test_random(input int which, input int n);
        int bdv, bfe, bpe, bov, adv, afe, ape, aov, outcome;
        logic [7:0] d;
        bit stop, par, full;
        for (int k = 0; k < n; k++) begin
            d       = 8'($urandom_range(0, 255));
            stop    = ($urandom_range(0, 5) != 0);
            par     = 1'($urandom_range(0, 1));
            full    = ($urandom_range(0, 3) == 0);
            outcome = model_outcome(d, which == 1, par, stop, full);
            if (which == 0) full0 = full;
            else full1 = full;
            snap(which, bdv, bfe, bpe, bov);
            send_frame(which, d, par, stop);
            full0 = 1'b0;
            full1 = 1'b0;
            snap(which, adv, afe, ape, aov);
            checks++;
            if ({adv - bdv, afe - bfe, ape - bpe, aov - bov} !==
                {int'(outcome == OUT_VALID), int'(outcome == OUT_FRAME),
                 int'(outcome == OUT_PARITY), int'(outcome == OUT_OVERRUN)}) begin
                errors++;
                $display("FAIL random%0d_events_%0d: dv %0d fe %0d pe %0d ov %0d expected outcome %0d",
                         which, k, adv - bdv, afe - bfe, ape - bpe, aov - bov, outcome);
            end
            if (outcome == OUT_VALID) begin
                checks++;
                if (got_at(which, bdv) !== d) begin
                    errors++;
                    $display("FAIL random%0d_data_%0d: got %h expected %h", which, k, got_at(which, bdv), d);
                end
                last_good[which] = d;
            end else begin
                checks++;
                if (dout_of(which) !== last_good[which]) begin
                    errors++;
                    $display("FAIL random%0d_hold_%0d: got %h expected %h", which, k, dout_of(which), last_good[which]);
                end
            end
            if (!stop || ($urandom_range(0, 1) == 1)) drive_bit(which, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_false_start();
        test_frame_err();
        test_overrun();
        test_parity();
        test_reset_mid();
        test_back_to_back();
        test_random(0, 16);
        test_random(1, 16);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
